// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one valid/ready data-memory request per access,
// stalls the pipeline until the response arrives, and aligns store data and load results.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       ALUResult,
  input  logic [63:0]       rd_data2,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [7:0]        wmask,
  input  logic [31:0]       inst_in,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [63:0]       dmem_rdata,
  output logic              stall_o,
  output logic [63:0]       load_data_o,
  output logic              load_valid_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [63:0]       wdata_reg;
  logic [7:0]        wstrb_reg;
  logic [2:0]        funct3_reg;
  logic [2:0]        off_reg;
  logic [CW-1:0]     cnt_reg;
  logic [63:0]       load_data_reg;
  logic              bus_err_reg;

  logic [2:0]  off;
  logic [2:0]  funct3;
  logic [3:0]  size_bytes;
  logic        acc;
  logic        mis;
  logic        launch;
  logic        capture;
  logic        err;
  logic        timeout;
  logic [63:0] shifted;
  logic [63:0] ext;

  logic unused;
  assign unused = ^{inst_in[31:15], inst_in[11:0], ALUResult[63:ADDR_W]};

  assign off        = ALUResult[2:0];
  assign funct3     = inst_in[14:12];
  assign size_bytes = 4'd1 << funct3[1:0];
  assign acc        = MemRead | MemWrite;
  assign mis        = acc && (({1'b0, off} + size_bytes) > 4'd8);
  assign launch     = (state == IDLE) && acc && !mis;
  assign timeout    = (cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: if (launch) state_next = REQ;
      REQ: begin
        if (dmem_req_ready && dmem_rsp_valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (timeout) begin
          err        = 1'b1;
          state_next = DONE;
        end else if (dmem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (timeout) begin
          err        = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane extraction, then size truncation with sign/zero extension.
  always_comb begin
    shifted = dmem_rdata >> {off_reg, 3'b000};
    ext     = shifted;
    case (funct3_reg[1:0])
      2'd0: ext = funct3_reg[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: ext = funct3_reg[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: ext = funct3_reg[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      funct3_reg    <= '0;
      off_reg       <= '0;
      cnt_reg       <= '0;
      load_data_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      state       <= state_next;
      bus_err_reg <= err;
      if (launch) begin
        // A simultaneous read+write is treated as a read, so no strobes.
        addr_reg   <= {ALUResult[ADDR_W-1:3], 3'b000};
        we_reg     <= MemWrite && !MemRead;
        wdata_reg  <= rd_data2 << {off, 3'b000};
        wstrb_reg  <= MemRead ? 8'h00 : (wmask << off);
        funct3_reg <= funct3;
        off_reg    <= off;
        cnt_reg    <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (err)
        load_data_reg <= '0;
      else if (capture && !we_reg)
        load_data_reg <= ext;
    end
  end

  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = we_reg;
  assign dmem_addr      = addr_reg;
  assign dmem_wdata     = wdata_reg;
  assign dmem_wstrb     = wstrb_reg;
  assign stall_o        = launch || (state == REQ) || (state == WAIT);
  assign load_data_o    = load_data_reg;
  assign load_valid_o   = (state == DONE) && !we_reg;
  assign misaligned_o   = (state == IDLE) && mis;
  assign bus_err_o      = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, backpressure, misalignment,
// response timeout and reset during an outstanding request.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ALUResult, rd_data2, dmem_rdata;
  logic        MemRead, MemWrite, dmem_req_ready, dmem_rsp_valid;
  logic [7:0]  wmask;
  logic [31:0] inst_in;
  logic        dmem_req_valid, dmem_we, stall_o, load_valid_o, misaligned_o, bus_err_o;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata, load_data_o;
  logic [7:0]  dmem_wstrb;

  int checks = 0;
  int failures = 0;
  int hs = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ALUResult(ALUResult), .rd_data2(rd_data2),
    .MemRead(MemRead), .MemWrite(MemWrite), .wmask(wmask), .inst_in(inst_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dmem_req_valid && dmem_req_ready) hs++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic [63:0] a, input logic [2:0] f3, input logic rd, input logic wr);
    ALUResult = a;
    inst_in   = {17'd0, f3, 12'd0};
    MemRead   = rd;
    MemWrite  = wr;
    #1;
  endtask

  // Zero-wait load: IDLE(acc) -> REQ -> WAIT(rsp) -> DONE.
  task automatic do_load(input string tag, input logic [63:0] a, input logic [2:0] f3,
                         input logic [63:0] rdata, input logic [63:0] exp);
    dmem_req_ready = 1'b1;
    set_acc(a, f3, 1'b1, 1'b0);
    chk({tag, "_stall_idle"}, stall_o, 1);
    step();
    chk({tag, "_req_valid"}, dmem_req_valid, 1);
    chk({tag, "_addr"}, dmem_addr, {a[63:3], 3'b000});
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_stall_req"}, stall_o, 1);
    step();
    chk({tag, "_stall_wait"}, stall_o, 1);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = rdata;
    step();
    dmem_rsp_valid = 1'b0;
    MemRead        = 1'b0;
    #1;
    chk({tag, "_stall_done"}, stall_o, 0);
    chk({tag, "_load_valid"}, load_valid_o, 1);
    chk({tag, "_load_data"}, load_data_o, exp);
    step();
    chk({tag, "_valid_drop"}, load_valid_o, 0);
    chk({tag, "_data_held"}, load_data_o, exp);
  endtask

  initial begin
    int n;
    int hs0;
    rst = 1'b1; ALUResult = '0; rd_data2 = '0; MemRead = 0; MemWrite = 0;
    wmask = '0; inst_in = '0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_load_data", load_data_o, 0);
    chk("rst_load_valid", load_valid_o, 0);
    chk("rst_bus_err", bus_err_o, 0);

    do_load("ld", 64'h100, 3'b011, 64'h8877665544332211, 64'h8877665544332211);
    do_load("lb", 64'h107, 3'b000, 64'h8000000000000000, 64'hFFFFFFFFFFFFFF80);
    do_load("lbu", 64'h107, 3'b100, 64'h8000000000000000, 64'h0000000000000080);
    do_load("lh", 64'h102, 3'b001, 64'h00000000F00D0000, 64'hFFFFFFFFFFFFF00D);

    // sw at 0x204
    wmask = 8'h0F; rd_data2 = 64'hDEADBEEF; dmem_req_ready = 1'b1;
    set_acc(64'h204, 3'b010, 1'b0, 1'b1);
    step();
    chk("sw_addr", dmem_addr, 64'h200);
    chk("sw_wstrb", dmem_wstrb, 8'hF0);
    chk("sw_wdata", dmem_wdata, 64'hDEADBEEF00000000);
    chk("sw_we", dmem_we, 1);
    step();
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0; MemWrite = 1'b0;
    #1;
    chk("sw_load_valid", load_valid_o, 0);
    chk("sw_stall_done", stall_o, 0);
    chk("sw_data_held", load_data_o, 64'hFFFFFFFFFFFFF00D);
    step();

    // Backpressure: ready low for 5 REQ cycles, inputs perturbed meanwhile.
    hs0 = hs;
    wmask = 8'hFF; rd_data2 = 64'h1122334455667788; dmem_req_ready = 1'b0;
    set_acc(64'h300, 3'b011, 1'b0, 1'b1);
    step();
    ALUResult = 64'h999; rd_data2 = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", dmem_req_valid, 1);
      chk("bp_addr", dmem_addr, 64'h300);
      chk("bp_wdata", dmem_wdata, 64'h1122334455667788);
      chk("bp_stall", stall_o, 1);
      step();
    end
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0; MemWrite = 1'b0;
    #1;
    chk("bp_done_stall", stall_o, 0);
    step();
    chk("bp_req_valid_idle", dmem_req_valid, 0);
    chk("bp_one_request", hs - hs0, 1);

    // Misaligned lw at 0x106
    set_acc(64'h106, 3'b010, 1'b1, 1'b0);
    chk("mis_pulse", misaligned_o, 1);
    chk("mis_stall", stall_o, 0);
    chk("mis_req_valid", dmem_req_valid, 0);
    step();
    MemRead = 1'b0;
    #1;
    chk("mis_no_req", dmem_req_valid, 0);
    chk("mis_drop", misaligned_o, 0);

    // Timeout: ld with no response
    set_acc(64'h110, 3'b011, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (load_valid_o) break;
    end
    MemRead = 1'b0;
    chk("to_cycles", n, 65);
    chk("to_bus_err", bus_err_o, 1);
    chk("to_load_data", load_data_o, 0);
    step();
    chk("to_bus_err_pulse", bus_err_o, 0);

    // Reset while WAIT, then late response
    set_acc(64'h118, 3'b011, 1'b1, 1'b0);
    step();
    step();
    chk("r6_in_wait", stall_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; MemRead = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 64'hCAFEF00DCAFEF00D;
    step();
    dmem_rsp_valid = 1'b0;
    #1;
    chk("r6_req_valid", dmem_req_valid, 0);
    chk("r6_we", dmem_we, 0);
    chk("r6_addr", dmem_addr, 0);
    chk("r6_wdata", dmem_wdata, 0);
    chk("r6_wstrb", dmem_wstrb, 0);
    chk("r6_stall", stall_o, 0);
    chk("r6_load_data", load_data_o, 0);
    chk("r6_load_valid", load_valid_o, 0);
    chk("r6_bus_err", bus_err_o, 0);
    step();
    chk("r6_load_valid_later", load_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
